// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the EX-stage ALU: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the 32-cycle multiply with a single-cycle combinational product.
module ex_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            squash_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES  = '1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN-1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic            sign1_en;
    logic            sign2_en;
    logic            s1;
    logic            s2;
    logic            res_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] special_res;

    // Accept-time decode: operand signedness, magnitudes, final sign and divide special cases
    always_comb begin
        sign1_en = !(op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
        sign2_en = (op_i == 3'd0 || op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6);
        s1       = sign1_en & op1_i[XLEN-1];
        s2       = sign2_en & op2_i[XLEN-1];
        mag1     = s1 ? -op1_i : op1_i;
        mag2     = s2 ? -op2_i : op2_i;
        case (op_i)
            3'd0, 3'd1, 3'd4: res_neg = s1 ^ s2;
            3'd2, 3'd6:       res_neg = s1;
            default:          res_neg = 1'b0;
        endcase
        div_zero = (op2_i == '0);
        div_ovf  = !op_i[0] && (op1_i == MIN_NEG) && (op2_i == ALL_ONES);
        if (div_zero) begin
            special_res = op_i[1] ? op1_i : ALL_ONES;
        end else begin
            special_res = op_i[1] ? '0 : MIN_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   mul_result;

    always_comb begin
        fast_prod  = {{XLEN{s1}}, op1_i} * {{XLEN{s2}}, op2_i};
        mul_result = (op_i == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi;
    logic [XLEN-1:0]   mul_lo;
    logic [2*XLEN-1:0] mul_mag;
    logic [2*XLEN-1:0] mul_signed;
    logic [XLEN-1:0]   mul_result;

    // Shift-add step: {hi,lo} shifts right while lo's LSB selects whether the multiplicand is added
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        mul_hi     = mul_sum[XLEN:1];
        mul_lo     = {mul_sum[0], lo_q[XLEN-1:1]};
        mul_mag    = {mul_hi, mul_lo};
        mul_signed = neg_q ? -mul_mag : mul_mag;
        mul_result = (op_q == 3'd0) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    end
`endif

    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_q_f;
    logic [XLEN-1:0] div_r_f;
    logic [XLEN-1:0] div_result;

    // Restoring step: hi holds the partial remainder, lo shifts the dividend out and the quotient in
    always_comb begin
        div_shift  = {hi_q, lo_q[XLEN-1]};
        div_ge     = (div_shift >= {1'b0, a_q});
        div_rem    = div_ge ? (div_shift[XLEN-1:0] - a_q) : div_shift[XLEN-1:0];
        div_quo    = {lo_q[XLEN-2:0], div_ge};
        div_q_f    = neg_q ? -div_quo : div_quo;
        div_r_f    = neg_q ? -div_rem : div_rem;
        div_result = op_q[1] ? div_r_f : div_q_f;
    end

    assign busy_o  = (state == MUL) || (state == DIV);
    assign done_o  = (state == DONE);
    assign stall_o = !rst_i && !squash_i && (((state == IDLE) && start_i) || busy_o);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !squash_i) begin
                        op_q  <= op_i;
                        neg_q <= res_neg;
                        cnt   <= '0;
                        if (op_i[2]) begin
                            a_q  <= mag2;
                            hi_q <= '0;
                            lo_q <= mag1;
                            if (div_zero || div_ovf) begin
                                result_o <= special_res;
                                state    <= DONE;
                            end else begin
                                state <= DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_o <= mul_result;
                            state    <= DONE;
`else
                            a_q   <= mag1;
                            hi_q  <= '0;
                            lo_q  <= mag2;
                            state <= MUL;
`endif
                        end
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                MUL: begin
                    if (squash_i) begin
                        state <= IDLE;
                    end else begin
                        hi_q <= mul_hi;
                        lo_q <= mul_lo;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            result_o <= mul_result;
                            state    <= DONE;
                        end
                    end
                end
`endif
                DIV: begin
                    if (squash_i) begin
                        state <= IDLE;
                    end else begin
                        hi_q <= div_rem;
                        lo_q <= div_quo;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            result_o <= div_result;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (squash_i || !hold_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed RV32M cases plus randomized ops against a behavioural model.
module tb_ex_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        squash_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    ex_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .op_i(op_i),
        .op1_i(op1_i),
        .op2_i(op2_i),
        .squash_i(squash_i),
        .hold_i(hold_i),
        .stall_o(stall_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .result_o(result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural result of an RV32M op computed with plain 64-bit arithmetic
    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles left until the result appears, plus whether a result is on offer
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_done) begin
            if (squash_i || !hold_i) m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (squash_i) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start_i && !squash_i) begin
            if (refLatency(op_i, op1_i, op2_i) == 1) begin
                m_done <= 1'b1;
                m_res  <= refResult(op_i, op1_i, op2_i);
            end else begin
                m_left <= refLatency(op_i, op1_i, op2_i) - 1;
                m_pend <= refResult(op_i, op1_i, op2_i);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_stall", {31'b0, stall_o},
                        {31'b0, !rst_i && !squash_i && ((m_left == 0 && !m_done && start_i) || m_left > 0)});
            checkOutput("cyc_busy", {31'b0, busy_o}, {31'b0, m_left > 0});
            checkOutput("cyc_done", {31'b0, done_o}, {31'b0, m_done});
            if (m_done) checkOutput("cyc_result", result_o, m_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int hold_n);
        int lat = 0;
        bit seen = 1'b0;
        op_i    = op;
        op1_i   = a;
        op2_i   = b;
        start_i = 1'b1;
        hold_i  = (hold_n > 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput({name, "_stall_T"}, {31'b0, stall_o}, 32'd1);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            step();
            lat++;
        end
        checkOutput({name, "_seen"}, {31'b0, seen}, 32'd1);
        checkOutput({name, "_lat"}, lat, exp_lat);
        checkOutput({name, "_res"}, result_o, exp_res);
        checkOutput({name, "_stall_done"}, {31'b0, stall_o}, 32'd0);
        for (int i = 1; i <= hold_n; i++) begin
            step();
            if (i == hold_n) hold_i = 1'b0;
            @(negedge clk);
            checkOutput({name, "_hold_done"}, {31'b0, done_o}, 32'd1);
            checkOutput({name, "_hold_res"}, result_o, exp_res);
        end
        step();
        start_i = 1'b0;
        hold_i  = 1'b0;
        @(negedge clk);
        checkOutput({name, "_idle_done"}, {31'b0, done_o}, 32'd0);
        checkOutput({name, "_idle_busy"}, {31'b0, busy_o}, 32'd0);
        step();
    endtask

    task automatic applyStimulus();
        int sq_at;
        int rs_at;
        bit finished;
        for (int t = 0; t < 150; t++) begin
            op_i  = 3'($urandom_range(0, 7));
            op1_i = pickOperand();
            op2_i = pickOperand();
            if ($urandom_range(0, 9) == 0) begin
                op1_i = 32'h8000_0000;
                op2_i = 32'hFFFF_FFFF;
            end
            sq_at    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 36)) : -1;
            rs_at    = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 36)) : -1;
            start_i  = 1'b1;
            finished = 1'b0;
            for (int c = 0; c < 100 && !finished; c++) begin
                squash_i = (c == sq_at);
                rst_i    = (c == rs_at);
                hold_i   = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                if (squash_i || rst_i || (done_o && !hold_i)) finished = 1'b1;
                step();
            end
            if (!finished) checkOutput("rand_timeout", 32'd0, 32'd1);
            start_i  = 1'b0;
            squash_i = 1'b0;
            rst_i    = 1'b0;
            hold_i   = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i    = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("reset_done", {31'b0, done_o}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall_o}, 32'd0);
        step();

        runOp("mul_7x6", 3'd0, 32'd7, 32'd6, 32'h0000_002A, MUL_LAT, 0);
        runOp("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 0);
        runOp("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
        runOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 0);
        runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 32'h0000_000E, 33, 0);
        runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        runOp("remu_z", 3'd7, 32'd7, 32'd0, 32'h0000_0007, 1, 0);
        runOp("divu_z", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
        runOp("div_hold", 3'd4, 32'd1000, 32'd10, 32'd100, 33, 3);
        runOp("mul_hold", 3'd0, 32'd7, 32'd6, 32'h0000_002A, MUL_LAT, 3);

        // Squash a divide ten cycles in
        op_i    = 3'd4;
        op1_i   = 32'd1000;
        op2_i   = 32'd3;
        start_i = 1'b1;
        repeat (10) step();
        squash_i = 1'b1;
        @(negedge clk);
        checkOutput("squash_stall", {31'b0, stall_o}, 32'd0);
        step();
        squash_i = 1'b0;
        start_i  = 1'b0;
        @(negedge clk);
        checkOutput("squash_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("squash_done", {31'b0, done_o}, 32'd0);
        repeat (40) step();

        // Reset five cycles into a divide clears everything
        op_i    = 3'd5;
        op1_i   = 32'd1000;
        op2_i   = 32'd3;
        start_i = 1'b1;
        repeat (5) step();
        rst_i = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall", {31'b0, stall_o}, 32'd0);
        step();
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_result", result_o, 32'd0);
        step();

        applyStimulus();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
